// File: rtl/axi_write_store_fwd.sv
// Store-and-forward AXI write buffer: an AW is released downstream only once its whole W burst
// is buffered. Define AXI_WSF_LEN_CHECK_EN to build the sticky burst-length checker (len_err_o).
package axi_wsf_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
    logic [3:0]  user;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [3:0]  user;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic [3:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  user;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;
endpackage

module axi_wsf_fifo #(
  parameter int unsigned Depth = 4,
  parameter type         T     = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  typedef logic [PtrW-1:0] ptr_t;

  T     mem [Depth];
  ptr_t wr_ptr, rd_ptr;
  logic full_q;
  logic do_push, do_pop;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Pointers wrap at Depth; full_q disambiguates wr_ptr == rd_ptr.
  assign empty   = (wr_ptr == rd_ptr) && !full_q;
  assign full    = full_q;
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop && (ptr_inc(wr_ptr) == rd_ptr)) full_q <= 1'b1;
      else if (do_pop && !do_push)                            full_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module axi_write_store_fwd #(
  parameter int unsigned AwDepth    = 4,
  parameter int unsigned WDepth     = 256,
  parameter type         aw_chan_t  = axi_wsf_pkg::aw_chan_t,
  parameter type         w_chan_t   = axi_wsf_pkg::w_chan_t,
  parameter type         axi_req_t  = axi_wsf_pkg::axi_req_t,
  parameter type         axi_resp_t = axi_wsf_pkg::axi_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i,
  output logic      busy_o,
  output logic      len_err_o
);
  localparam int unsigned CntW = $clog2(WDepth + 1);

  if (WDepth < 256) begin : g_wdepth_chk
    $fatal(1, "axi_write_store_fwd: WDepth must hold a full 256-beat burst");
  end
  if (AwDepth < 1) begin : g_awdepth_chk
    $fatal(1, "axi_write_store_fwd: AwDepth must be at least 1");
  end

  typedef enum logic {IDLE, W_SEND} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cmpl_cnt_q;
  aw_chan_t        aw_head;
  w_chan_t         w_head;
  logic            aw_full, aw_empty, w_full, w_empty;
  logic            slv_aw_hs, slv_w_hs, mst_aw_hs, mst_w_hs;
  logic            mst_aw_valid, mst_w_valid;
  logic            in_last, out_last;

  assign slv_aw_hs = slv_req_i.aw_valid && !aw_full;
  assign slv_w_hs  = slv_req_i.w_valid && !w_full;
  assign mst_aw_hs = mst_aw_valid && mst_resp_i.aw_ready;
  assign mst_w_hs  = mst_w_valid && mst_resp_i.w_ready;
  assign in_last   = slv_w_hs && slv_req_i.w.last;
  assign out_last  = mst_w_hs && w_head.last;

  axi_wsf_fifo #(.Depth(AwDepth), .T(aw_chan_t)) i_aw_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (slv_req_i.aw_valid),
    .wdata (slv_req_i.aw),
    .pop   (mst_aw_hs),
    .rdata (aw_head),
    .full  (aw_full),
    .empty (aw_empty)
  );

  axi_wsf_fifo #(.Depth(WDepth), .T(w_chan_t)) i_w_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (slv_req_i.w_valid),
    .wdata (slv_req_i.w),
    .pop   (mst_w_hs),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Number of complete bursts sitting in the W FIFO; gates AW release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmpl_cnt_q <= '0;
    end else if (in_last && !out_last) begin
      cmpl_cnt_q <= cmpl_cnt_q + CntW'(1);
    end else if (out_last && !in_last) begin
      cmpl_cnt_q <= cmpl_cnt_q - CntW'(1);
    end
  end

  // cmpl_cnt only drops in W_SEND, so a raised aw_valid stays up until its handshake.
  assign mst_aw_valid = (state_q == IDLE) && !aw_empty && (cmpl_cnt_q != '0);
  assign mst_w_valid  = (state_q == W_SEND) && !w_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mst_aw_hs) state_d = W_SEND;
      W_SEND:  if (out_last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw       = aw_head;
    mst_req_o.aw_valid = mst_aw_valid;
    mst_req_o.w        = w_head;
    mst_req_o.w_valid  = mst_w_valid;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = !aw_full;
    slv_resp_o.w_ready  = !w_full;
  end

  assign busy_o = !aw_empty || !w_empty || (state_q != IDLE);

`ifdef AXI_WSF_LEN_CHECK_EN
  logic [8:0] beat_cnt_q, exp_beats_q, beat_num;
  logic       len_err_q;

  assign beat_num = beat_cnt_q + 9'd1;

  // Flags a last on the wrong beat as well as a missing last at the expected beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q  <= '0;
      exp_beats_q <= '0;
      len_err_q   <= 1'b0;
    end else begin
      if (mst_aw_hs) begin
        exp_beats_q <= 9'(aw_head.len) + 9'd1;
        beat_cnt_q  <= '0;
      end
      if (mst_w_hs) begin
        beat_cnt_q <= beat_num;
        if (w_head.last != (beat_num == exp_beats_q)) len_err_q <= 1'b1;
      end
    end
  end

  assign len_err_o = len_err_q;
`else
  assign len_err_o = 1'b0;
`endif
endmodule
